// File: rtl/trail_pkg.sv
// Shared definitions for the LED trail monitor: the eight legal Johnson
// codes in trail order, the 16-entry code-to-phase table and the FSM state
// type with its encodings.
package trail_pkg;

  localparam int unsigned CODE_W   = 4;
  localparam int unsigned PHASE_W  = 3;
  localparam int unsigned N_PHASES = 8;
  localparam int unsigned N_CODES  = 16;

  typedef logic [CODE_W-1:0]  code_t;
  typedef logic [PHASE_W-1:0] phase_t;

  // FSM state type; encodings kept as plain constants for legacy tools
  typedef logic [0:0] state_t;
  localparam state_t ST_ACQ  = 1'b0;
  localparam state_t ST_LOCK = 1'b1;

  // Result of decoding one synchronized trail code
  typedef struct packed {
    logic   legal;
    phase_t phase;
  } decode_t;

  // Legal codes indexed by trail position (phase -> code)
  localparam code_t LEGAL_CODES [N_PHASES] = '{
    4'b0000, 4'b1000, 4'b1100, 4'b1110,
    4'b1111, 4'b0111, 4'b0011, 4'b0001
  };

  // Code-to-phase table indexed by the raw 4-bit code (code -> phase)
  localparam decode_t CODE_TABLE [N_CODES] = '{
    '{legal: 1'b1, phase: 3'd0},  // 0000
    '{legal: 1'b1, phase: 3'd7},  // 0001
    '{legal: 1'b0, phase: 3'd0},  // 0010
    '{legal: 1'b1, phase: 3'd6},  // 0011
    '{legal: 1'b0, phase: 3'd0},  // 0100
    '{legal: 1'b0, phase: 3'd0},  // 0101
    '{legal: 1'b0, phase: 3'd0},  // 0110
    '{legal: 1'b1, phase: 3'd5},  // 0111
    '{legal: 1'b1, phase: 3'd1},  // 1000
    '{legal: 1'b0, phase: 3'd0},  // 1001
    '{legal: 1'b0, phase: 3'd0},  // 1010
    '{legal: 1'b0, phase: 3'd0},  // 1011
    '{legal: 1'b1, phase: 3'd2},  // 1100
    '{legal: 1'b0, phase: 3'd0},  // 1101
    '{legal: 1'b1, phase: 3'd3},  // 1110
    '{legal: 1'b1, phase: 3'd4}   // 1111
  };

  // Table lookup wrapper so callers never index with a mismatched width
  function automatic decode_t trail_decode(input code_t code);
    return CODE_TABLE[code];
  endfunction

endpackage

// File: rtl/trail_sync2.sv
// Two-flop synchronizer for the 4-bit asynchronous trail pattern.
// Ports: clk, resetn (async active-low, clears both stages to 0),
//        d (asynchronous input), q (synchronized output).
module trail_sync2
  import trail_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic [CODE_W-1:0] d,
  output logic [CODE_W-1:0] q
);

  logic [CODE_W-1:0] meta;

  // Metastability-settling stage followed by the output stage
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/trail_monitor.sv
// LED trail monitor: synchronizes a 4-bit Johnson-code trail, tracks its
// position, flags legal forward steps and faults, and counts faults.
// Optional macro TRAIL_MON_STALL_EN adds a stall timer that raises `stall`
// after 2^STALL_W cycles without a change; without it `stall` is tied 0.
// Ports:
//   clk, resetn   - clock, async active-low reset
//   pat[3:0]      - trail pattern, asynchronous to clk
//   phase[2:0]    - decoded trail position
//   locked        - tracker is in the LOCK state
//   step / err    - one-cycle pulses: legal advance / fault
//   err_cnt       - saturating count of err pulses
//   stall         - level, no input change for 2^STALL_W cycles
module trail_monitor
  import trail_pkg::*;
#(
  parameter int unsigned STALL_W = 24,
  parameter int unsigned CNT_W   = 8
)
(
  input  logic               clk,
  input  logic               resetn,
  input  logic [CODE_W-1:0]  pat,
  output logic [PHASE_W-1:0] phase,
  output logic               locked,
  output logic               step,
  output logic               err,
  output logic [CNT_W-1:0]   err_cnt,
  output logic               stall
);

  code_t   s;
  code_t   p;
  decode_t dec;
  logic    changed;
  logic    fwd;

  state_t  state_q;
  state_t  state_nxt;
  phase_t  phase_nxt;
  logic    step_nxt;
  logic    err_nxt;

  trail_sync2 u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (pat),
    .q      (s)
  );

  // One-cycle-delayed copy of the synchronized code for change detection
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      p <= '0;
    end else begin
      p <= s;
    end
  end

  assign dec     = trail_decode(s);
  assign changed = (s != p);
  // Forward advance means the new code is exactly the next one in the trail
  assign fwd     = (s == LEGAL_CODES[PHASE_W'(phase + PHASE_W'(1))]);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_ACQ;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state and pulse decode
  always_comb begin
    state_nxt = state_q;
    phase_nxt = phase;
    step_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state_q)
      ST_ACQ: begin
        // Illegal codes are simply waited out while acquiring
        if (dec.legal) begin
          state_nxt = ST_LOCK;
          phase_nxt = dec.phase;
        end
      end
      ST_LOCK: begin
        if (changed) begin
          if (!dec.legal) begin
            err_nxt   = 1'b1;
            state_nxt = ST_ACQ;
          end else if (fwd) begin
            step_nxt  = 1'b1;
            phase_nxt = dec.phase;
          end else begin
            // Skip or reverse: resynchronize to the observed position
            err_nxt   = 1'b1;
            phase_nxt = dec.phase;
          end
        end
      end
      default: begin
        state_nxt = ST_ACQ;
      end
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase  <= '0;
      locked <= 1'b0;
      step   <= 1'b0;
      err    <= 1'b0;
    end else begin
      phase  <= phase_nxt;
      locked <= (state_nxt == ST_LOCK);
      step   <= step_nxt;
      err    <= err_nxt;
    end
  end

  // Saturating fault counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_cnt <= '0;
    end else if (err_nxt && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

`ifdef TRAIL_MON_STALL_EN
  logic [STALL_W-1:0] stall_cnt;
  logic [STALL_W-1:0] stall_cnt_nxt;

  // Idle timer: restarts on any change or while acquiring, sticks at max
  always_comb begin
    stall_cnt_nxt = stall_cnt;
    if (changed || (state_q == ST_ACQ)) begin
      stall_cnt_nxt = '0;
    end else if (stall_cnt != {STALL_W{1'b1}}) begin
      stall_cnt_nxt = stall_cnt + STALL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
      stall     <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt_nxt;
      stall     <= &stall_cnt_nxt;
    end
  end
`else
  // Timer not built; STALL_W only shapes the interface in this build
  assign stall = 1'b0 && (STALL_W != 0);
`endif

endmodule

// File: tb/tb_trail_monitor.sv
// Directed self-checking bench for trail_monitor: reset, full trail cycle
// with wrap, skip/illegal/reverse faults, reacquisition, err_cnt saturation,
// stall timer (when TRAIL_MON_STALL_EN is defined) and mid-run reset.
module tb_trail_monitor;

  localparam int unsigned CNT_W = 8;
`ifdef TRAIL_MON_STALL_EN
  localparam int unsigned TB_STALL_W = 4;
`else
  localparam int unsigned TB_STALL_W = 24;
`endif

  logic             clk;
  logic             resetn;
  logic [3:0]       pat;
  logic [2:0]       phase;
  logic             locked;
  logic             step;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  logic             stall;

  int unsigned n_checks;
  int unsigned n_fail;

  trail_monitor #(
    .STALL_W (TB_STALL_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .pat     (pat),
    .phase   (phase),
    .locked  (locked),
    .step    (step),
    .err     (err),
    .err_cnt (err_cnt),
    .stall   (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles; ends just after a falling edge
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Apply a code and move to the cycle where its step/err pulse is visible
  task automatic drive(input logic [3:0] code);
    pat = code;
    tick(3);
  endtask

  logic [3:0] cyc [8];
  int         steps;
  int         errs;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};

    // Reset values
    resetn = 1'b0;
    pat    = 4'b0000;
    tick(3);
    check("rst_phase",   32'(phase),   32'd0);
    check("rst_locked",  32'(locked),  32'd0);
    check("rst_step",    32'(step),    32'd0);
    check("rst_err",     32'(err),     32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_stall",   32'(stall),   32'd0);

    // Acquire on 0000
    resetn = 1'b1;
    tick(4);
    check("acq_locked", 32'(locked), 32'd1);
    check("acq_phase",  32'(phase),  32'd0);
    check("acq_step",   32'(step),   32'd0);
    check("acq_err",    32'(err),    32'd0);

    // Full forward cycle, 10 cycles per code, wrapping 7 -> 0
    steps = 0;
    errs  = 0;
    for (int i = 0; i < 8; i++) begin
      pat = cyc[i];
      for (int k = 0; k < 10; k++) begin
        tick(1);
        steps += int'(step);
        errs  += int'(err);
        if (k == 2) begin
          check("cyc_step",  32'(step),  32'd1);
          check("cyc_phase", 32'(phase), 32'((i + 1) % 8));
        end
      end
    end
    check("cyc_steps",   32'(steps),   32'd8);
    check("cyc_errs",    32'(errs),    32'd0);
    check("cyc_err_cnt", 32'(err_cnt), 32'd0);
    check("cyc_phase_end", 32'(phase), 32'd0);

    // Skip from phase 2 to phase 4
    drive(4'b1000); tick(5);
    drive(4'b1100);
    check("skip_pre_phase", 32'(phase), 32'd2);
    tick(5);
    drive(4'b1111);
    check("skip_err",     32'(err),     32'd1);
    check("skip_step",    32'(step),    32'd0);
    check("skip_phase",   32'(phase),   32'd4);
    check("skip_locked",  32'(locked),  32'd1);
    check("skip_err_cnt", 32'(err_cnt), 32'd1);
    tick(1);
    check("skip_err_pulse", 32'(err), 32'd0);
    tick(4);

    // Illegal code drops lock; legal code reacquires without err
    drive(4'b0101);
    check("ill_err",     32'(err),     32'd1);
    check("ill_locked",  32'(locked),  32'd0);
    check("ill_phase",   32'(phase),   32'd4);
    check("ill_err_cnt", 32'(err_cnt), 32'd2);
    tick(1);
    check("ill_err_pulse", 32'(err),   32'd0);
    check("ill_hold_acq",  32'(locked), 32'd0);
    tick(4);
    drive(4'b0011);
    check("reacq_locked",  32'(locked),  32'd1);
    check("reacq_phase",   32'(phase),   32'd6);
    check("reacq_err",     32'(err),     32'd0);
    check("reacq_step",    32'(step),    32'd0);
    check("reacq_err_cnt", 32'(err_cnt), 32'd2);
    tick(5);

    // Reverse step 6 -> 5
    drive(4'b0111);
    check("rev_err",     32'(err),     32'd1);
    check("rev_phase",   32'(phase),   32'd5);
    check("rev_err_cnt", 32'(err_cnt), 32'd3);
    tick(5);

    // 300 faults: err_cnt saturates at 255
    errs = 0;
    for (int j = 0; j < 300; j++) begin
      pat = (j % 2 == 0) ? 4'b1000 : 4'b1110;
      for (int k = 0; k < 4; k++) begin
        tick(1);
        errs += int'(err);
      end
      if (j == 99) check("sat_mid_cnt", 32'(err_cnt), 32'd103);
    end
    check("sat_errs",    32'(errs),    32'd300);
    check("sat_err_cnt", 32'(err_cnt), 32'd255);
    check("sat_locked",  32'(locked),  32'd1);
    check("sat_phase",   32'(phase),   32'd3);
    tick(4);

`ifdef TRAIL_MON_STALL_EN
    // Stall timer with STALL_W = 4
    drive(4'b1111);
    check("stl_step0",  32'(step),  32'd1);
    check("stl_phase0", 32'(phase), 32'd4);
    tick(14);
    check("stl_not_yet", 32'(stall), 32'd0);
    tick(1);
    check("stl_set",     32'(stall), 32'd1);
    tick(3);
    check("stl_hold",    32'(stall), 32'd1);
    drive(4'b0111);
    check("stl_clear",   32'(stall), 32'd0);
    check("stl_step1",   32'(step),  32'd1);
    check("stl_err",     32'(err),   32'd0);
    tick(5);
`else
    tick(40);
    check("stl_tied", 32'(stall), 32'd0);
`endif

    // Reset mid-operation discards the pending pulse
    pat = 4'b0011;
    tick(2);
    resetn = 1'b0;
    #1;
    check("mid_rst_step",    32'(step),    32'd0);
    check("mid_rst_err",     32'(err),     32'd0);
    check("mid_rst_locked",  32'(locked),  32'd0);
    check("mid_rst_phase",   32'(phase),   32'd0);
    check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    check("mid_rst_stall",   32'(stall),   32'd0);
    tick(2);
    check("mid_rst_no_pulse", 32'(step | err), 32'd0);
    pat = 4'b0000;
    tick(2);
    resetn = 1'b1;
    tick(1);
    check("post_rst_locked", 32'(locked), 32'd1);
    check("post_rst_phase",  32'(phase),  32'd0);
    tick(3);
    check("post_rst_quiet",   32'(step | err), 32'd0);
    check("post_rst_err_cnt", 32'(err_cnt),    32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
